// File: rtl/int_sched.sv
// Interrupt scheduler: synchronizes six IRQ sources, latches pending bits, masks,
// picks a fixed-priority winner and tracks it through service via EXL and EOI.
module int_sched #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0F00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  irq_src,
  input  logic        exl,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [5:0]  INT,
  output logic [31:0] rd,
  output logic        hit
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_SERVICE} st_t;

  st_t         r_st, w_st_nxt;
  logic [2:0]  r_cur, w_cur_nxt;
  logic [5:0]  r_sync [SYNC_STAGES];
  logic [5:0]  r_s_d, r_pend, r_mask, r_mode;
  logic [5:0]  w_s, w_rise, w_clr, w_cand, w_pend_nxt;
  logic [2:0]  w_win;
  logic        w_none, w_wr, w_eoi_match;
  logic [1:0]  w_off;
  logic        w_unused;

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_off    = addr[3:2];
  assign w_wr     = we & hit;
  assign w_unused = ^{addr[1:0], wd[31:6]};

  assign w_eoi_match = w_wr && (w_off == 2'd3) && (wd[2:0] == r_cur) && (r_st == ST_SERVICE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_s_d <= '0;
    end else begin
      r_sync[0] <= irq_src;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_s_d <= w_s;
    end
  end

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;

  // Edge bits: set beats any clear landing the same cycle; level bits track s.
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_off == 2'd0)) w_clr = wd[5:0];
    if (w_eoi_match)             w_clr = w_clr | (6'b1 << r_cur);
    w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & w_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_wr && (w_off == 2'd1)) r_mask <= wd[5:0];
      if (w_wr && (w_off == 2'd2)) r_mode <= wd[5:0];
    end
  end

  assign w_cand = r_pend & r_mask;
  assign w_none = (w_cand == '0);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    w_win = '0;
    for (int unsigned i = 6; i > 0; i--) begin
      if (w_cand[i-1]) w_win = 3'(i - 1);
    end
  end

  always_comb begin
    rd = '0;
    case (w_off)
      2'd0: rd[5:0] = r_pend;
      2'd1: rd[5:0] = r_mask;
      2'd2: rd[5:0] = r_mode;
      default: begin
        rd[31]  = w_none;
        rd[2:0] = w_win;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= ST_IDLE;
      r_cur <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cur <= w_cur_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_cur_nxt = r_cur;
    case (r_st)
      ST_IDLE: begin
        if (!w_none) begin
          w_cur_nxt = w_win;
          w_st_nxt  = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (exl)                                w_st_nxt = ST_SERVICE;
        else if ((w_cand & (6'b1 << r_cur)) == '0) w_st_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (w_eoi_match) w_st_nxt = ST_IDLE;
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    INT = '0;
    if (r_st == ST_ACTIVE) INT = 6'b1 << r_cur;
  end

endmodule
